// File: rtl/elastic_stage_reg.sv
// Elastic valid/ready stage register: 1-cycle latency; full throughput; freeze holds, flush empties.
// SKID=1 gives a 2-entry skid buffer so in_ready is registered; SKID=0 gives a 1-entry stage with combinational in_ready.
module elastic_stage_reg #(
  parameter int DATA_W = 102,
  parameter bit SKID   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              freeze,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              m_valid_q, m_valid_d;
  logic              s_valid_q, s_valid_d;
  logic [DATA_W-1:0] m_data_q,  m_data_d;
  logic [DATA_W-1:0] s_data_q,  s_data_d;
  logic              accept;
  logic              send;

  always_comb begin
    if (SKID) begin
      in_ready = ~s_valid_q & ~freeze & ~flush;
    end else begin
      in_ready = (~m_valid_q | out_ready) & ~freeze & ~flush;
    end
    out_valid = m_valid_q & ~freeze;
    out_data  = m_data_q;
    occupancy = {1'b0, m_valid_q} + {1'b0, s_valid_q};
    accept    = in_valid & in_ready;
    send      = out_valid & out_ready;
  end

  always_comb begin
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    m_data_d  = m_data_q;
    s_data_d  = s_data_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
      m_data_d  = '0;
      s_data_d  = '0;
    end else if (!freeze) begin
      if (!m_valid_q) begin
        if (accept) begin
          m_valid_d = 1'b1;
          m_data_d  = in_data;
        end
      end else if (send) begin
        // S always drains into M first to keep strict FIFO order
        if (s_valid_q) begin
          m_data_d = s_data_q;
          if (accept) begin
            s_data_d = in_data;
          end else begin
            s_valid_d = 1'b0;
          end
        end else if (accept) begin
          m_data_d = in_data;
        end else begin
          m_valid_d = 1'b0;
        end
      end else if (accept) begin
        s_valid_d = 1'b1;
        s_data_d  = in_data;
      end
    end
    if (!SKID) begin
      s_valid_d = 1'b0;
      s_data_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      m_data_q  <= '0;
      s_data_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      m_data_q  <= m_data_d;
      s_data_q  <= s_data_d;
    end
  end

endmodule

// File: doc/elastic_stage_reg.md
# elastic_stage_reg

Parametrised pipeline stage register with a valid/ready handshake, replacing fixed-field stage registers between pipeline stages (e.g. MEM→WB) with a generic elastic stage. It holds one payload word of configurable width, optionally with a skid entry so upstream `in_ready` has no combinational path from downstream `out_ready`. It also provides the existing `freeze` (hold) and `flush` (kill) controls.

## Interface
Parameters:
- `DATA_W`, 102: payload width. Default packs WB_EN, MEM_R_EN, ALU result, memory read value, Dest and PC (1+1+32+32+4+32).
- `SKID`, 1: 1 selects a 2-entry skid stage with registered `in_ready`; 0 selects a 1-entry stage with combinational `in_ready`.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous kill of all held entries.
- `freeze`  in  1  synchronous hold of all state.
- `in_valid`  in  1  upstream payload valid.
- `in_ready`  out  1  stage can accept.
- `in_data`  in  DATA_W  upstream payload.
- `out_valid`  out  1  payload available downstream.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  DATA_W  payload to downstream.
- `occupancy`  out  2  number of held entries, 0..2.

## Operation
- State:
  - Main entry M: `m_valid`, `m_data`. M drives `out_data` directly.
  - Skid entry S: `s_valid`, `s_data`. S exists only when `SKID=1`; otherwise `s_valid` is tied to 0.
- `out_valid = m_valid & ~freeze`.
- `out_data = m_data`. It is held stable while `out_valid & ~out_ready`.
- `in_ready`:
  - `SKID=1`: `~s_valid & ~freeze & ~flush`.
  - `SKID=0`: `(~m_valid | out_ready) & ~freeze & ~flush`.
- Accept is `in_valid & in_ready`. Send is `out_valid & out_ready`.
- Priority per clock edge:
  - `flush` first: `m_valid`, `s_valid` ← 0 and `m_data`, `s_data` ← 0. This applies even if `freeze=1`.
  - `freeze` next: no state change.
- Otherwise, the next state by case:
  - M empty, accept: M ← in.
  - M full, send, accept: if S is valid, M ← S and S ← in; else M ← in.
  - M full, send, no accept: M ← S if `s_valid`, else M empty. S becomes empty.
  - M full, no send, accept (`SKID=1` only): S ← in.
  - M full, no send, no accept: hold.
- Ordering is strict FIFO. No payload is dropped or duplicated except by `flush`.
- `occupancy = m_valid + s_valid`.
- Invariant: `s_valid` implies `m_valid`.

## Timing
- Reset (`rst=0`, asynchronous): `m_valid`, `s_valid`, `m_data`, `s_data` = 0.
  - Outputs during reset: `out_valid=0`, `out_data=0`, `occupancy=0`.
  - `in_ready=1` during reset if `freeze=0` and `flush=0`.
  - Release is synchronous to the first `clk` edge after `rst` rises.
- Latency: a payload accepted at edge N is on `out_data`, with `out_valid=1`, after edge N.
- Throughput: 1 payload per cycle with `out_ready` held high, for both `SKID` values.
- `SKID=1`:
  - `in_ready` depends only on registered state plus `freeze`/`flush`.
  - After `out_ready` drops, the stage absorbs exactly one further payload, then `in_ready=0` from the next cycle.
- `SKID=0`:
  - Full (`occupancy=1`) with `out_ready=1`: accept and send occur in the same cycle.
  - Full with `out_ready=0`: `in_ready=0`.
- Reset mid-transfer: all held payloads are discarded immediately. No partial output.
- Flush and accept in the same cycle: the input is not accepted (`in_ready=0`) and the stage is empty after the edge.
- Freeze: `out_valid` and `in_ready` are forced to 0 combinationally. On release, prior contents reappear unchanged.

## Test plan
- Reset then stream: reset, then `in_data` = 1,2,3,4 with `in_valid=1` and `out_ready=1`. Required: `out_data` shows 1,2,3,4 on consecutive cycles, each one cycle after its accept, with `occupancy=1` throughout.
- Backpressure, `SKID=1`: stream 10,11,12 and drop `out_ready` in the cycle 10 is presented. Required: 11 is accepted into S, `occupancy=2`, `in_ready=0`. When `out_ready` rises, the output is 10,11,12 in order with no loss.
- Backpressure, `SKID=0`: same stimulus. Required: `in_ready` falls in the same cycle as `out_ready`, `occupancy` never exceeds 1, and the order is preserved.
- Flush with `occupancy=2` (contents 0xA, 0xB) and `in_valid=1` carrying 0xC. Required: after the edge, `occupancy=0`, `out_valid=0`, `out_data=0`, and 0xC is never output.
- Freeze for 3 cycles with M=0x55 and `out_ready=1`. Required: `out_valid=0` and `in_ready=0` throughout, state unchanged. After release, 0x55 is sent next cycle. Freeze together with flush: the stage is empty after the edge.
- Async reset asserted mid-edge-interval with `occupancy=2`. Required: `out_valid` and `occupancy` go to 0 immediately, without waiting for `clk`.
